// File: rtl/data_sram_bridge_pkg.sv
// Shared defines for the M-stage data SRAM bridge.
// Bridge FSM state encodings and bus transfer size codes.
package data_sram_bridge_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/data_sram_bridge.sv
// M-stage data-side SRAM-like bus master; one transaction outstanding at most.
// Optional POSTED_STORE_EN: stores retire on addr_ok, the next access waits for their data_ok.
module data_sram_bridge
    import data_sram_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                mem_en,
    input  logic [DATA_W/8-1:0] mem_wen,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_kill,
    input  logic                flush,
    input  logic                pipe_stall,
    output logic                data_req,
    output logic                data_wr,
    output logic [1:0]          data_size,
    output logic [ADDR_W-1:0]   data_addr,
    output logic [DATA_W/8-1:0] data_wstrb,
    output logic [DATA_W-1:0]   data_wdata,
    input  logic                data_addr_ok,
    input  logic                data_data_ok,
    input  logic [DATA_W-1:0]   data_rdata,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                d_stall
);

    logic [1:0] state;
    logic       drop;
    logic       go;
    logic       posted_wr;
    logic       posted_done;
    logic       issue_ok;

    assign go        = mem_en & ~mem_kill & ~flush;
    assign data_size = SIZE_WORD;
    assign data_req  = (state == S_REQ);

`ifdef POSTED_STORE_EN
    logic st_pend;

    assign posted_wr = data_wr;
    assign issue_ok  = ~st_pend;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st_pend <= 1'b0;
        end else if (posted_done & ~data_data_ok) begin
            st_pend <= 1'b1;
        end else if (data_data_ok) begin
            st_pend <= 1'b0;
        end
    end
`else
    assign posted_wr = 1'b0;
    assign issue_ok  = 1'b1;
`endif

    assign posted_done = data_req & data_addr_ok & posted_wr;

    // A posted store lets the pipeline go in the cycle its address is accepted.
    assign d_stall = ((state == S_IDLE) & go)
                   | (data_req & ~posted_done)
                   | (state == S_WAIT);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            drop       <= 1'b0;
            data_wr    <= 1'b0;
            data_addr  <= '0;
            data_wstrb <= '0;
            data_wdata <= '0;
            mem_rdata  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (go) begin
                        data_wr    <= |mem_wen;
                        data_addr  <= mem_addr;
                        data_wstrb <= mem_wen;
                        data_wdata <= mem_wdata;
                        if (issue_ok) state <= S_REQ;
                    end
                end
                S_REQ: begin
                    // The request cannot be withdrawn; a flush only marks the reply dead.
                    if (flush & ~posted_wr) drop <= 1'b1;
                    if (data_addr_ok) begin
                        if (posted_wr) begin
                            state <= (pipe_stall & ~flush) ? S_DONE : S_IDLE;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (data_data_ok) begin
                        if (drop | flush) begin
                            drop  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            if (!data_wr) mem_rdata <= data_rdata;
                            state <= S_DONE;
                        end
                    end else if (flush) begin
                        drop <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (~pipe_stall | flush) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed plus randomized bench for data_sram_bridge against a transaction-level model.
// Build with POSTED_STORE_EN to also cover the posted-store path.
module tb_data_sram_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_kill;
    logic        flush;
    logic        pipe_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic [31:0] mem_rdata;
    logic        d_stall;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_rdata;

    always #5 clk = ~clk;

    data_sram_bridge dut (
        .clk          (clk),
        .resetn       (resetn),
        .mem_en       (mem_en),
        .mem_wen      (mem_wen),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_kill     (mem_kill),
        .flush        (flush),
        .pipe_stall   (pipe_stall),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_rdata    (mem_rdata),
        .d_stall      (d_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_en       = 1'b0;
        mem_kill     = 1'b0;
        flush        = 1'b0;
        pipe_stall   = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
    endtask

    // One complete access: addr_ok on the (a+1)th request cycle, data_ok b cycles
    // after acceptance, then ps cycles of pipe_stall while the result is held.
    task automatic access(input logic wr, input logic [3:0] wen,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input int a, input int b,
                          input int ps);
        int phase, reqc, waitc, stallc, reqs;
        logic prev_req;
        phase = 0; reqc = 0; waitc = 0; stallc = 0; reqs = 0;
        prev_req = 1'b0;
        idle_inputs();
        mem_en    = 1'b1;
        mem_wen   = wr ? wen : 4'b0000;
        mem_addr  = addr;
        mem_wdata = wd;
        for (int c = 0; c < 60 && phase != 2; c++) begin
            data_addr_ok = 1'b0;
            data_data_ok = 1'b0;
            data_rdata   = $urandom;
            if (phase == 1) begin
                if (waitc == b) begin
                    data_data_ok = 1'b1;
                    data_rdata   = rd;
                    phase        = 2;
                end
                waitc++;
            end else if (data_req) begin
                chk("req_addr", data_addr, addr);
                chk("req_wr", data_wr, wr);
                chk("req_wstrb", data_wstrb, wr ? wen : 4'b0000);
                chk("req_wdata", data_wdata, wd);
                chk("req_size", data_size, 2'b10);
                if (reqc == a) begin
                    data_addr_ok = 1'b1;
                    phase        = 1;
                end
                reqc++;
            end
            #1;
            stallc += d_stall;
            if (data_req && !prev_req) reqs++;
            prev_req = data_req;
            cyc();
        end
        chk("timeout", phase, 2);
        if (!wr) model_rdata = rd;
        chk("req_cycles", reqc, a + 1);
        chk("stall_cycles", stallc, a + b + 3);
        chk("req_count", reqs, 1);
        for (int i = 0; i <= ps; i++) begin
            pipe_stall   = (i < ps);
            data_addr_ok = 1'b0;
            data_data_ok = $urandom_range(0, 1);
            data_rdata   = $urandom;
            #1;
            chk("done_stall", d_stall, 1'b0);
            chk("done_req", data_req, 1'b0);
            chk("done_rdata", mem_rdata, model_rdata);
            cyc();
        end
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old;
        logic        wr;
        idle_inputs();
        mem_wen     = 4'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        data_rdata  = '0;
        model_rdata = '0;
        resetn      = 1'b0;
        #2;
        chk("rst_req", data_req, 1'b0);
        chk("rst_wr", data_wr, 1'b0);
        chk("rst_addr", data_addr, 32'h0);
        chk("rst_wstrb", data_wstrb, 4'h0);
        chk("rst_wdata", data_wdata, 32'h0);
        chk("rst_rdata", mem_rdata, 32'h0);
        chk("rst_size", data_size, 2'b10);
        chk("rst_stall", d_stall, 1'b0);
        repeat (2) cyc();
        resetn = 1'b1;
        cyc();

        // Minimum-latency load
        access(1'b0, 4'b0, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
        chk("t1_rdata", mem_rdata, 32'hDEAD_BEEF);

`ifndef POSTED_STORE_EN
        // Store with the address phase held off
        access(1'b1, 4'b1100, 32'h0000_2008, 32'h1234_1234, 32'h5555_0000, 2, 0, 0);
        chk("t2_rdata", mem_rdata, 32'hDEAD_BEEF);
`endif

        // Killed access never reaches the bus
        mem_en   = 1'b1;
        mem_kill = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("kill_stall", d_stall, 1'b0);
            chk("kill_req", data_req, 1'b0);
            cyc();
        end
        idle_inputs();
        #1;
        chk("kill_req_after", data_req, 1'b0);
        cyc();

        // Flush while waiting for data
        old      = mem_rdata;
        mem_en   = 1'b1;
        mem_wen  = 4'b0;
        mem_addr = 32'h0000_3000;
        cyc();
        data_addr_ok = 1'b1;
        #1;
        chk("fw_req", data_req, 1'b1);
        cyc();
        data_addr_ok = 1'b0;
        flush        = 1'b1;
        mem_en       = 1'b0;
        #1;
        chk("fw_stall", d_stall, 1'b1);
        cyc();
        flush = 1'b0;
        cyc();
        data_data_ok = 1'b1;
        data_rdata   = 32'hAAAA_AAAA;
        cyc();
        data_data_ok = 1'b0;
        #1;
        chk("fw_rdata", mem_rdata, old);
        chk("fw_stall_after", d_stall, 1'b0);
        chk("fw_req_after", data_req, 1'b0);
        cyc();

        // Flush during the request phase: request held, reply dropped
        mem_en   = 1'b1;
        mem_addr = 32'h0000_3010;
        cyc();
        flush  = 1'b1;
        mem_en = 1'b0;
        cyc();
        flush = 1'b0;
        #1;
        chk("fr_req_held", data_req, 1'b1);
        data_addr_ok = 1'b1;
        cyc();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'hBBBB_BBBB;
        cyc();
        data_data_ok = 1'b0;
        #1;
        chk("fr_rdata", mem_rdata, old);
        chk("fr_stall", d_stall, 1'b0);
        cyc();

        // data_ok together with flush counts as dropped
        mem_en   = 1'b1;
        mem_addr = 32'h0000_3020;
        cyc();
        data_addr_ok = 1'b1;
        cyc();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'hCCCC_CCCC;
        flush        = 1'b1;
        mem_en       = 1'b0;
        cyc();
        idle_inputs();
        #1;
        chk("fs_rdata", mem_rdata, old);
        chk("fs_stall", d_stall, 1'b0);
        cyc();

        // Stray data_ok while idle
        data_data_ok = 1'b1;
        data_rdata   = 32'h0BAD_F00D;
        cyc();
        data_data_ok = 1'b0;
        #1;
        chk("stray_rdata", mem_rdata, old);
        cyc();

        // Load completing under a 4-cycle external stall
        access(1'b0, 4'b0, 32'h0000_4000, 32'h0, 32'h7777_1111, 1, 1, 4);

`ifdef POSTED_STORE_EN
        // Posted store followed back-to-back by a load
        old       = mem_rdata;
        mem_en    = 1'b1;
        mem_wen   = 4'b0011;
        mem_addr  = 32'h0000_5000;
        mem_wdata = 32'h9999_9999;
        #1;
        chk("ps_issue_stall", d_stall, 1'b1);
        cyc();
        chk("ps_req", data_req, 1'b1);
        chk("ps_wr", data_wr, 1'b1);
        data_addr_ok = 1'b1;
        #1;
        chk("ps_release", d_stall, 1'b0);
        cyc();
        data_addr_ok = 1'b0;
        mem_wen      = 4'b0;
        mem_addr     = 32'h0000_6004;
        for (int k = 2; k < 8; k++) begin
            data_data_ok = (k == 6);
            data_rdata   = 32'h1357_2468;
            #1;
            chk("ps_hold_req", data_req, 1'b0);
            chk("ps_hold_stall", d_stall, 1'b1);
            chk("ps_hold_rdata", mem_rdata, old);
            cyc();
        end
        data_data_ok = 1'b0;
        chk("ps_load_req", data_req, 1'b1);
        chk("ps_load_addr", data_addr, 32'h0000_6004);
        chk("ps_load_wr", data_wr, 1'b0);
        data_addr_ok = 1'b1;
        cyc();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'h2468_ACE0;
        cyc();
        idle_inputs();
        model_rdata = 32'h2468_ACE0;
        #1;
        chk("ps_load_rdata", mem_rdata, model_rdata);
        chk("ps_load_stall", d_stall, 1'b0);
        cyc();
`endif

        // Randomized accesses
        for (int n = 0; n < 40; n++) begin
`ifdef POSTED_STORE_EN
            wr = 1'b0;
`else
            wr = 1'($urandom_range(0, 1));
`endif
            access(wr, 4'($urandom_range(1, 15)), $urandom & 32'hFFFF_FFFC,
                   $urandom, $urandom, $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Reset in the middle of a request
        mem_en   = 1'b1;
        mem_wen  = 4'b0;
        mem_addr = 32'h0000_7000;
        cyc();
        chk("mr_req", data_req, 1'b1);
        mem_en = 1'b0;
        resetn = 1'b0;
        #1;
        model_rdata = '0;
        chk("mr_req_clr", data_req, 1'b0);
        chk("mr_addr_clr", data_addr, 32'h0);
        chk("mr_rdata_clr", mem_rdata, model_rdata);
        chk("mr_stall", d_stall, 1'b0);
        resetn = 1'b1;
        cyc();
        access(1'b0, 4'b0, 32'h0000_7004, 32'h0, 32'h0F0F_F0F0, 0, 2, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
